// File: rtl/sum_input_loader_if.sv
// Port bundle for sum_input_loader: element stream, kernel launch/read/return, result stream.
// The timeout signal exists only when SUM_LOADER_TIMEOUT_EN is defined.
interface sum_input_loader_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              kern_start;
    logic [31:0]       kern_n;
    logic [ADDR_W-1:0] kern_rd_addr;
    logic [31:0]       kern_rd_data;
    logic              kern_done;
    logic [31:0]       kern_ret;
    logic [31:0]       res_data;
    logic              res_valid;
    logic              res_ready;
    logic              trunc;
    logic              busy;
`ifdef SUM_LOADER_TIMEOUT_EN
    logic              timeout;

    modport slave (
        input  in_data, in_valid, in_last, kern_rd_addr, kern_done, kern_ret, res_ready,
        output in_ready, kern_start, kern_n, kern_rd_data, res_data, res_valid, trunc, busy, timeout
    );
    modport master (
        output in_data, in_valid, in_last, kern_rd_addr, kern_done, kern_ret, res_ready,
        input  in_ready, kern_start, kern_n, kern_rd_data, res_data, res_valid, trunc, busy, timeout
    );
`else
    modport slave (
        input  in_data, in_valid, in_last, kern_rd_addr, kern_done, kern_ret, res_ready,
        output in_ready, kern_start, kern_n, kern_rd_data, res_data, res_valid, trunc, busy
    );
    modport master (
        output in_data, in_valid, in_last, kern_rd_addr, kern_done, kern_ret, res_ready,
        input  in_ready, kern_start, kern_n, kern_rd_data, res_data, res_valid, trunc, busy
    );
`endif
endinterface

// File: rtl/sum_input_loader.sv
// Streams one batch of 32-bit words into local RAM, launches the prefix-sum kernel on it,
// serves its reads and hands back its return value. Optional watchdog: SUM_LOADER_TIMEOUT_EN.
module sum_input_loader #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    sum_input_loader_if.slave    bus
);
    if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("sum_input_loader: inconsistent DEPTH/ADDR_W/TIMEOUT");
    end

    typedef enum logic [1:0] {S_LOAD, S_LAUNCH, S_WAIT, S_RESULT} state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] count;
    logic [31:0]     kern_n, rd_data, res_data;
    logic            res_valid, trunc;
    logic [31:0]     mem [DEPTH];
    logic            xfer, full_hit, expire;

    assign xfer     = bus.in_valid && bus.in_ready;
    assign full_hit = (count == (ADDR_W+1)'(DEPTH - 1));

`ifdef SUM_LOADER_TIMEOUT_EN
    logic [31:0] wdog;
    logic        timeout;

    // kern_done on the expiry cycle takes priority, so expire is qualified by !kern_done.
    assign expire      = (state == S_WAIT) && !bus.kern_done && (wdog == 32'(TIMEOUT - 1));
    assign bus.timeout = timeout;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_LOAD;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.in_ready   = 1'b0;
        bus.kern_start = 1'b0;
        case (state)
            S_LOAD: begin
                bus.in_ready = (count < (ADDR_W+1)'(DEPTH));
                if (xfer && (bus.in_last || full_hit)) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                bus.kern_start = 1'b1;
                state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                if (bus.kern_done || expire) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (bus.res_ready) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Buffer contents survive reset; only the write enable is suppressed.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && xfer) mem[count[ADDR_W-1:0]] <= bus.in_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count     <= '0;
            kern_n    <= '0;
            rd_data   <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            trunc     <= 1'b0;
`ifdef SUM_LOADER_TIMEOUT_EN
            wdog      <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            rd_data <= mem[bus.kern_rd_addr];
            case (state)
                S_LOAD: begin
                    if (xfer) begin
                        count <= count + (ADDR_W+1)'(1);
                        if (bus.in_last) begin
                            kern_n <= 32'(count) + 32'd1;
                        end else if (full_hit) begin
                            kern_n <= 32'(DEPTH);
                            trunc  <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
`ifdef SUM_LOADER_TIMEOUT_EN
                    wdog <= '0;
`endif
                end
                S_WAIT: begin
`ifdef SUM_LOADER_TIMEOUT_EN
                    wdog <= wdog + 32'd1;
`endif
                    if (bus.kern_done) begin
                        res_data  <= bus.kern_ret;
                        res_valid <= 1'b1;
                    end else if (expire) begin
                        res_data  <= 32'hDEAD_BEEF;
                        res_valid <= 1'b1;
`ifdef SUM_LOADER_TIMEOUT_EN
                        timeout   <= 1'b1;
`endif
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        trunc     <= 1'b0;
                        count     <= '0;
`ifdef SUM_LOADER_TIMEOUT_EN
                        timeout   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.kern_n       = kern_n;
    assign bus.kern_rd_data = rd_data;
    assign bus.res_data     = res_data;
    assign bus.res_valid    = res_valid;
    assign bus.trunc        = trunc;
    assign bus.busy         = !(state == S_LOAD && count == '0);
endmodule

// File: tb/tb_sum_input_loader.sv
// Directed + randomized bench for sum_input_loader; the kernel is modelled as a summing reader.
`timescale 1ns/1ps
module tb_sum_input_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
`ifdef SUM_LOADER_TIMEOUT_EN
    localparam int TIMEOUT = 16;
    localparam int KDLY    = 3;
`else
    localparam int TIMEOUT = 4096;
    localparam int KDLY    = 20;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   errors  = 0;
    int   checks  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] words [$];
    logic [31:0] sum;

    sum_input_loader_if #(.ADDR_W(ADDR_W)) bus ();

    sum_input_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves in_valid high; caller drops it when the stream pauses.
    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("send_wait_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
    endtask

    task automatic send_batch();
        foreach (exp_q[i]) send_word(exp_q[i], i == exp_q.size() - 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] s = '0;
        foreach (exp_q[i]) s += exp_q[i];
        return s;
    endfunction

    // Called in the LAUNCH cycle; reads a sample of the batch back and returns its sum.
    task automatic run_kernel(input int dly, input logic exp_trunc);
        int idx [$];
        int n = exp_q.size();
        sum = model_sum();
        check("kern_start", 32'(bus.kern_start), 32'd1);
        check("kern_n", bus.kern_n, 32'(n));
        check("trunc_launch", 32'(bus.trunc), 32'(exp_trunc));
        check("in_ready_launch", 32'(bus.in_ready), 32'd0);
        check("busy_launch", 32'(bus.busy), 32'd1);
        if (n <= 8) for (int i = 0; i < n; i++) idx.push_back(i);
        else for (int i = 0; i < 4; i++) begin idx.push_back(i); idx.push_back(n - 4 + i); end
        foreach (idx[k]) begin
            bus.kern_rd_addr = ADDR_W'(idx[k]);
            tick();
            if (k == 0) check("kern_start_pulse", 32'(bus.kern_start), 32'd0);
            check($sformatf("rd_data[%0d]", idx[k]), bus.kern_rd_data, exp_q[idx[k]]);
        end
        repeat (dly) tick();
        check("res_valid_pre", 32'(bus.res_valid), 32'd0);
        bus.kern_ret  = sum;
        bus.kern_done = 1'b1;
        tick();
        bus.kern_done = 1'b0;
        check("res_valid", 32'(bus.res_valid), 32'd1);
        check("res_data", bus.res_data, sum);
        check("in_ready_result", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic accept(input logic [31:0] exp_data, input logic exp_trunc, input int hold);
        for (int i = 0; i < hold; i++) begin
            check("hold_res_valid", 32'(bus.res_valid), 32'd1);
            tick();
        end
        check("acc_res_data", bus.res_data, exp_data);
        check("acc_trunc", 32'(bus.trunc), 32'(exp_trunc));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("post_res_valid", 32'(bus.res_valid), 32'd0);
        check("post_trunc", 32'(bus.trunc), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SUM_LOADER_TIMEOUT_EN
        check("post_timeout", 32'(bus.timeout), 32'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"},   32'(bus.in_ready),   32'd1);
        check({pfx, "_kern_start"}, 32'(bus.kern_start), 32'd0);
        check({pfx, "_kern_n"},     bus.kern_n,          32'd0);
        check({pfx, "_rd_data"},    bus.kern_rd_data,    32'd0);
        check({pfx, "_res_data"},   bus.res_data,        32'd0);
        check({pfx, "_res_valid"},  32'(bus.res_valid),  32'd0);
        check({pfx, "_trunc"},      32'(bus.trunc),      32'd0);
        check({pfx, "_busy"},       32'(bus.busy),       32'd0);
`ifdef SUM_LOADER_TIMEOUT_EN
        check({pfx, "_timeout"},    32'(bus.timeout),    32'd0);
`endif
    endtask

    initial begin
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.kern_rd_addr = '0; bus.kern_done = 1'b0; bus.kern_ret = '0;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;
        check_reset_outputs("reset");

        // Basic 4-word batch
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_batch();
        run_kernel(KDLY, 1'b0);
        check("basic_sum", bus.res_data, 32'd10);
        accept(32'd10, 1'b0, 0);

        // DEPTH+3 words: truncated first batch, remainder forms the second
        words.delete();
        for (int i = 0; i < DEPTH + 3; i++) words.push_back($urandom);
        exp_q = words[0:DEPTH-1];
        for (int i = 0; i < DEPTH; i++) send_word(words[i], 1'b0);
        bus.in_data = words[DEPTH];
        run_kernel(2, 1'b1);
        check("trunc_in_ready_wait", 32'(bus.in_ready), 32'd0);
        accept(sum, 1'b1, 0);
        exp_q = words[DEPTH:DEPTH+2];
        send_batch();
        run_kernel(2, 1'b0);
        accept(sum, 1'b0, 0);

        // Result held off for 10 cycles with a spurious second kern_done
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back($urandom);
        send_batch();
        run_kernel(1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.kern_done = (i == 3);
            bus.kern_ret  = ~sum;
            tick();
            bus.kern_done = 1'b0;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", bus.res_data, sum);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        accept(sum, 1'b0, 0);

        // Reset during WAIT, stale kern_done, then batch {5,7}
        exp_q = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
        send_batch();
        bus.kern_rd_addr = '0;
        repeat (3) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_reset_outputs("midrst");
        bus.kern_ret  = 32'd123;
        bus.kern_done = 1'b1;
        tick();
        bus.kern_done = 1'b0;
        check("stale_done_res_valid", 32'(bus.res_valid), 32'd0);
        check("stale_done_busy", 32'(bus.busy), 32'd0);
        exp_q = '{32'd5, 32'd7};
        send_batch();
        run_kernel(2, 1'b0);
        accept(32'd12, 1'b0, 0);

        // Single all-ones element
        exp_q = '{32'hFFFF_FFFF};
        send_batch();
        run_kernel(0, 1'b0);
        accept(32'hFFFF_FFFF, 1'b0, 0);

        // Random batches with random kernel latency and consumer stalls
        for (int b = 0; b < 5; b++) begin
            exp_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) exp_q.push_back($urandom);
            send_batch();
            run_kernel(int'($urandom_range(0, 2)), 1'b0);
            accept(sum, 1'b0, int'($urandom_range(0, 3)));
        end

`ifdef SUM_LOADER_TIMEOUT_EN
        // Watchdog expiry after TIMEOUT WAIT cycles
        exp_q = '{32'd9};
        send_batch();
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            check($sformatf("wd_quiet[%0d]", k), 32'(bus.res_valid), 32'd0);
        end
        tick();
        check("wd_res_valid", 32'(bus.res_valid), 32'd1);
        check("wd_res_data", bus.res_data, 32'hDEAD_BEEF);
        check("wd_timeout", 32'(bus.timeout), 32'd1);
        accept(32'hDEAD_BEEF, 1'b0, 0);

        // kern_done on the expiry cycle wins
        send_batch();
        repeat (TIMEOUT) tick();
        check("wd_race_quiet", 32'(bus.res_valid), 32'd0);
        bus.kern_ret  = 32'h0000_1234;
        bus.kern_done = 1'b1;
        tick();
        bus.kern_done = 1'b0;
        check("wd_race_res_data", bus.res_data, 32'h0000_1234);
        check("wd_race_timeout", 32'(bus.timeout), 32'd0);
        accept(32'h0000_1234, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sum_input_loader.md
Name: sum_input_loader

Overview:
- Upstream feeder for the array prefix-sum kernel.
- Accepts a valid/ready stream of 32-bit elements and buffers one batch in local RAM. Launches the kernel with n = element count and serves the kernel's a[i] reads.
- Captures the kernel's return value and presents it on a valid/ready result port.
- Replaces the kernel's file-preloaded input memory with a streamed one.

Parameters:
- DEPTH, 256, buffer capacity in 32-bit words (power of 2, ≥2)
- ADDR_W, 8, log2(DEPTH)
- TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- in_data  in  32  stream element
- in_valid  in  1  in_data valid
- in_last  in  1  element is the last of its batch
- in_ready  out  1  block can accept an element
- kern_start  out  1  one-cycle launch pulse to kernel
- kern_n  out  32  element count of current batch, stable from start until result accepted
- kern_rd_addr  in  ADDR_W  kernel read index
- kern_rd_data  out  32  buffer[kern_rd_addr], registered, 1-cycle latency
- kern_done  in  1  kernel result valid (single-cycle pulse or level)
- kern_ret  in  32  kernel return value, sampled when kern_done=1
- res_data  out  32  captured result
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- trunc  out  1  batch cut at DEPTH before in_last was seen
- busy  out  1  high in every state except LOAD with count=0

Behaviour:
- Element handshake: an element transfers when in_valid && in_ready. Result handshake: res_valid && res_ready.
- Reset (synchronous, checked every edge, overrides everything):
  - state=LOAD, count=0.
  - in_ready=1, kern_start=0, kern_n=0, kern_rd_data=0, res_data=0, res_valid=0, trunc=0, busy=0.
  - Buffer contents are undefined after reset.
  - Reset mid-batch or mid-kernel discards the batch. A later kern_done is ignored until the next launch.
- LOAD:
  - in_ready=1 while count<DEPTH.
  - Each transfer writes buffer[count] and increments count.
  - Transfer with in_last=1 → kern_n=count+1, next state LAUNCH.
  - Transfer filling slot DEPTH-1 without in_last → kern_n=DEPTH, trunc=1, next state LAUNCH. The remaining stream words stay held by the producer and form the next batch.
  - Last element and full buffer in the same transfer → trunc=0.
- LAUNCH:
  - Lasts exactly one cycle: kern_start=1, in_ready=0.
  - Next state WAIT.
- WAIT:
  - in_ready=0.
  - kern_rd_data updates every cycle from kern_rd_addr. Addresses ≥kern_n return stale buffer contents; this is not an error.
  - kern_done=1 → res_data=kern_ret, res_valid=1, next state RESULT.
  - kern_done in LOAD, LAUNCH or RESULT is ignored.
- RESULT:
  - res_valid held high and res_data stable until res_ready=1.
  - On the handshake: res_valid=0, trunc=0, count=0, next state LOAD. in_ready rises the following cycle.
- Latency: last element accepted at cycle t → kern_start at t+1, first kern_rd_data usable at t+2.
- Only one batch is in flight; there is no input buffering during WAIT or RESULT.
- Width rules:
  - count is ADDR_W+1 bits; kern_n is zero-extended to 32.
  - No arithmetic is performed on kern_ret.

Optional Feature:
- Macro SUM_LOADER_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without kern_done: res_data=32'hDEAD_BEEF, res_valid=1, extra output port timeout=1, next state RESULT.
  - timeout clears with the result handshake.
  - kern_done arriving on the same cycle the watchdog expires wins: normal result, timeout=0.
- Undefined: no watchdog, no timeout port; WAIT persists until kern_done.

Test Plan:
- Stream 4 words {1,2,3,4} with in_last on the 4th; model kernel returns 10 after 20 cycles → kern_start one pulse one cycle after last accept, kern_n=4, kern_rd_data for addr 0..3 = 1,2,3,4 with 1-cycle latency, res_data=10, trunc=0.
- Stream DEPTH+3 words with in_last on the final word → first batch kern_n=256, trunc=1. After the result handshake, the second batch gives kern_n=3, trunc=0.
- Hold res_ready=0 for 10 cycles after kern_done → res_valid and res_data stable, in_ready=0, a second kern_done pulse is ignored. Then res_ready=1 → in_ready=1 on the next cycle.
- Assert sys_rst for 1 cycle during WAIT, then stream a new 2-word batch {5,7} → all outputs at reset values the cycle after reset; new launch has kern_n=2; a stale kern_done issued before the new kern_start is ignored.
- Single-element batch {32'hFFFF_FFFF} with in_last → kern_n=1, kern_rd_data(0)=32'hFFFF_FFFF.
- With SUM_LOADER_TIMEOUT_EN and TIMEOUT=16, launch without ever asserting kern_done → res_valid after 16 WAIT cycles, res_data=32'hDEAD_BEEF, timeout=1. Repeat with kern_done on cycle 16 → normal result, timeout=0.
